inst_loader: RTL and testbench

Boot-time writer for the CPU's 512-word instruction memory. It accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit words, and writes them to consecutive instruction-memory addresses starting at word 0. It holds the CPU core in reset while loading and releases it only after the last word is committed, so the core always fetches from PC 0 over a complete image.

---
 rtl/loader_pkg.sv | 14 +
 rtl/byte_packer.sv | 37 +++
 rtl/inst_loader.sv | 119 +++++++++++
 tb/tb_inst_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared loader state encodings and instruction-memory geometry
package loader_pkg;

    localparam int LDR_DATA_WIDTH = 32;
    localparam int LDR_NUM_INSTS  = 512;
    localparam int LDR_ADDR_WIDTH = 9;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - little-endian assembly of four stream bytes into one word
module byte_packer (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt;
    logic [23:0] acc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= 2'd0;
            acc <= 24'd0;
        end else if (clear) begin
            cnt <= 2'd0;
            acc <= 24'd0;
        end else if (in_valid) begin
            cnt <= cnt + 2'd1;
            case (cnt)
                2'd0:    acc[7:0]   <= in_data;
                2'd1:    acc[15:8]  <= in_data;
                2'd2:    acc[23:16] <= in_data;
                default: acc        <= 24'd0;
            endcase
        end
    end

    // The fourth byte is forwarded combinationally so the word is complete on its accept edge.
    assign word_valid = in_valid && (cnt == 2'd3);
    assign word       = {in_data, acc};

endmodule

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - boot-time instruction-memory loader holding the core in reset
module inst_loader
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH     = LDR_DATA_WIDTH,
    parameter int NUM_INSTS      = LDR_NUM_INSTS,
    parameter int ADDR_WIDTH     = LDR_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len_words,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  cpu_rstn,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           checksum
);

    localparam int                  IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0]   IDLE_LAST  = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH:0] MAX_LEN    = (ADDR_WIDTH + 1)'(NUM_INSTS);

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [ADDR_WIDTH-1:0] last_idx;
    logic [ADDR_WIDTH-1:0] last_idx_nxt;
    logic [ADDR_WIDTH:0]   len_m1;
    logic [IDLE_W-1:0]     idle_cnt;
    logic                  xfer;
    logic                  can_start;
    logic                  len_legal;
    logic                  load_entry;
    logic                  last_word;
    logic                  timeout_hit;
    logic                  word_valid;
    logic [31:0]           word;

    assign xfer        = byte_valid && (state == ST_LOAD);
    assign can_start   = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
    assign len_legal   = (len_words != '0) && (len_words <= MAX_LEN);
    assign load_entry  = start && can_start && len_legal;
    assign last_word   = word_valid && (word_idx == last_idx);
    assign timeout_hit = !xfer && (idle_cnt == IDLE_LAST);
    assign len_m1      = len_words - (ADDR_WIDTH + 1)'(1);
    assign last_idx_nxt = len_m1[ADDR_WIDTH-1:0];

    byte_packer u_packer (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (load_entry),
        .in_valid   (xfer),
        .in_data    (byte_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_nxt = len_legal ? ST_LOAD : ST_ERR;
            end
            ST_LOAD: begin
                if (last_word)        state_nxt = ST_DRAIN;
                else if (timeout_hit) state_nxt = ST_ERR;
            end
            ST_DRAIN: state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            word_idx   <= '0;
            last_idx   <= '0;
            idle_cnt   <= '0;
            checksum   <= 32'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rstn   <= 1'b0;
        end else begin
            state    <= state_nxt;
            // Release follows the DONE entry so the final write has committed first.
            cpu_rstn <= (state_nxt == ST_DONE);
            imem_we  <= word_valid;
            if (load_entry) begin
                word_idx <= '0;
                last_idx <= last_idx_nxt;
                idle_cnt <= '0;
                checksum <= 32'd0;
            end else if (state == ST_LOAD) begin
                idle_cnt <= xfer ? '0 : idle_cnt + IDLE_W'(1);
                if (word_valid) begin
                    word_idx   <= word_idx + ADDR_WIDTH'(1);
                    checksum   <= checksum + word;
                    imem_addr  <= word_idx;
                    imem_wdata <= DATA_WIDTH'(word);
                end
            end
        end
    end

    assign byte_ready = (state == ST_LOAD);
    assign busy       = (state == ST_LOAD) || (state == ST_DRAIN);
    assign done       = (state == ST_DONE);
    assign error      = (state == ST_ERR);

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - randomized self-checking bench for inst_loader
module tb_inst_loader;

    localparam int NI = 512;
    localparam int AW = 9;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   len_words = '0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'd0;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rstn;
    logic          busy;
    logic          done;
    logic          error;
    logic [31:0]   checksum;

    always #5 clk = ~clk;

    inst_loader #(
        .DATA_WIDTH     (32),
        .NUM_INSTS      (NI),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .len_words  (len_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rstn   (cpu_rstn),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .checksum   (checksum)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [7:0]  tx_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] exp_sum;
    int          wr_cnt[NI];
    int          we_total = 0;
    int          last_we_addr = -1;
    int          last_we_cyc = 0;
    int          cyc = 0;
    logic        prev_we = 1'b0;
    logic        prev_crst = 1'b0;
    logic [63:0] mon_e;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (imem_we) begin
            we_total++;
            wr_cnt[imem_addr]++;
            last_we_addr = int'(imem_addr);
            last_we_cyc  = cyc;
            check("we_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(imem_addr), mon_e[63:32]);
                check("wr_data", 64'(imem_wdata), {32'd0, mon_e[31:0]});
            end
            check("we_width", prev_we, 0);
        end
        if (cpu_rstn && !prev_crst)
            check("release_latency", cyc - last_we_cyc, 1);
        prev_we   = imem_we;
        prev_crst = cpu_rstn;
    end

    task automatic fill_random(input int n);
        tx_q.delete();
        for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom_range(255)));
    endtask

    task automatic do_start(input int len);
        @(negedge clk);
        start     = 1'b1;
        len_words = (AW + 1)'(len);
        @(negedge clk);
        start     = 1'b0;
        exp_sum   = 32'd0;
    endtask

    // mode 0: back-to-back, 1: valid toggles each cycle, 2: random gaps
    task automatic send(input int mode, input int nbytes);
        int   i = 0;
        int   budget = 0;
        int   idle = 0;
        bit   ph = 1'b1;
        bit   v;
        bit   acc;
        logic [31:0] w;
        while (i < nbytes && budget < nbytes * 8 + 50) begin
            @(negedge clk);
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = ph;
            else                v = ($urandom_range(3) != 0) || (idle >= 6);
            ph = !ph;
            byte_valid = v;
            byte_data  = tx_q[i];
            acc = v && byte_ready;
            if (acc && (i % 4 == 3)) begin
                w = 32'(tx_q[i-3]) + 32'(tx_q[i-2]) * 32'd256
                  + 32'(tx_q[i-1]) * 32'd65536 + 32'(tx_q[i]) * 32'd16777216;
                exp_sum = exp_sum + w;
                exp_q.push_back((64'(i / 4) << 32) | 64'(w));
            end
            @(posedge clk);
            budget++;
            if (acc) begin
                i++;
                idle = 0;
            end else begin
                idle++;
            end
        end
        check("send_bytes_accepted", i, nbytes);
    endtask

    task automatic wait_done();
        int k = 0;
        @(negedge clk);
        byte_valid = 1'b0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("done", done, 1);
        check("cpu_rstn_done", cpu_rstn, 1);
        check("busy_done", busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},    byte_ready, 0);
        check({tag, "_we"},       imem_we, 0);
        check({tag, "_flags"},    {busy, done, error}, 0);
        check({tag, "_addr"},     64'(imem_addr), 0);
        check({tag, "_wdata"},    64'(imem_wdata), 0);
        check({tag, "_checksum"}, 64'(checksum), 0);
        check({tag, "_cpu_rstn"}, cpu_rstn, 0);
    endtask

    initial begin
        int we0;
        int badaddr;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;

        // Two-word load from the spec example
        tx_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        we0 = we_total;
        do_start(2);
        check("ready_after_start", byte_ready, 1);
        check("cpu_rstn_load", cpu_rstn, 0);
        send(0, 8);
        wait_done();
        check("two_word_checksum", 64'(checksum), 64'h0000_0000_0010_00A6);
        check("two_word_writes", we_total - we0, 2);

        // Same random 4-word image in three stream patterns
        fill_random(16);
        for (int m = 0; m < 3; m++) begin
            we0 = we_total;
            do_start(4);
            send(m, 16);
            wait_done();
            check("pattern_checksum", 64'(checksum), 64'(exp_sum));
            check("pattern_writes", we_total - we0, 4);
        end

        // Illegal lengths
        foreach (tx_q[k]) tx_q[k] = tx_q[k];
        for (int t = 0; t < 2; t++) begin
            we0 = we_total;
            do_start(t == 0 ? 0 : NI + 1);
            check("illegal_error", error, 1);
            check("illegal_ready", byte_ready, 0);
            check("illegal_cpu_rstn", cpu_rstn, 0);
            byte_valid = 1'b1;
            repeat (5) @(negedge clk);
            byte_valid = 1'b0;
            check("illegal_ready_held", byte_ready, 0);
            check("illegal_no_write", we_total - we0, 0);
        end

        // Timeout after a partial word
        fill_random(3);
        we0 = we_total;
        do_start(2);
        send(0, 3);
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("timeout_not_yet", {busy, error}, 2'b10);
        @(posedge clk);
        @(negedge clk);
        check("timeout_error", error, 1);
        check("timeout_cpu_rstn", cpu_rstn, 0);
        check("timeout_no_write", we_total - we0, 0);

        // Reset in the middle of a load, then a one-word reload
        fill_random(8);
        we0 = we_total;
        do_start(2);
        send(0, 5);
        @(negedge clk);
        byte_valid = 1'b0;
        rstn = 1'b0;
        #1;
        check_reset_outputs("midload_reset");
        check("midload_first_word_written", we_total - we0, 1);
        @(negedge clk);
        rstn = 1'b1;
        tx_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        do_start(1);
        send(0, 4);
        wait_done();
        check("reload_word", 64'(imem_wdata), 64'h0000_0000_DDCC_BBAA);
        check("reload_addr", 64'(imem_addr), 0);

        // Full 512-word image with random gaps, then reload from DONE
        for (int a = 0; a < NI; a++) wr_cnt[a] = 0;
        fill_random(NI * 4);
        do_start(NI);
        send(2, NI * 4);
        wait_done();
        check("full_checksum", 64'(checksum), 64'(exp_sum));
        badaddr = 0;
        for (int a = 0; a < NI; a++) if (wr_cnt[a] != 1) badaddr++;
        check("full_each_addr_once", badaddr, 0);
        check("full_last_addr", last_we_addr, NI - 1);

        fill_random(4);
        do_start(1);
        check("reload_cpu_rstn_low", cpu_rstn, 0);
        check("reload_checksum_clear", 64'(checksum), 0);
        check("reload_busy", busy, 1);
        send(1, 4);
        wait_done();
        check("reload_checksum", 64'(checksum), 64'(exp_sum));
        check("all_expected_written", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
